// File: rtl/serial_display_pkg.sv
// Shared constants, types and the ASCII decode helper for the scanned
// 7-segment display path.
package serial_display_pkg;

    // One buffer entry: blank flag plus the hex nibble it would show.
    typedef struct packed {
        logic       blank;
        logic [3:0] nibble;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, nibble: 4'h0};

    // Active-low {dp,g,f,e,d,c,b,a} codes, dp always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // ASCII codes and range bounds.
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_F = 8'h46;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_F = 8'h66;

    // Returns {valid, nibble}; nibble is zero when the character is not hex.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] ascii,
                                                   input logic       lower_ok);
        logic [7:0] offset_s;
        logic [4:0] result_s;
        offset_s = 8'h00;
        result_s = 5'b0_0000;
        if ((ascii >= ASCII_0) && (ascii <= ASCII_9)) begin
            offset_s = ascii - ASCII_0;
            result_s = {1'b1, offset_s[3:0]};
        end else if ((ascii >= ASCII_UPPER_A) && (ascii <= ASCII_UPPER_F)) begin
            offset_s = ascii - ASCII_UPPER_A + 8'd10;
            result_s = {1'b1, offset_s[3:0]};
        end else if (lower_ok && (ascii >= ASCII_LOWER_A) && (ascii <= ASCII_LOWER_F)) begin
            offset_s = ascii - ASCII_LOWER_A + 8'd10;
            result_s = {1'b1, offset_s[3:0]};
        end else begin
            result_s = 5'b0_0000;
        end
        return result_s;
    endfunction

endpackage

// File: rtl/serial_display_scan_hex_to_seg.sv
// Combinational {blank, nibble} to active-low 7-segment code.
module hex_to_seg
    import serial_display_pkg::*;
(
    input  logic [4:0] digit,
    output logic [7:0] seg
);

    // Segment lookup; blank entries and anything unexpected show all-off.
    always_comb begin
        seg = SEG_BLANK;
        if (digit[4]) begin
            seg = SEG_BLANK;
        end else begin
            case (digit[3:0])
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                4'hF:    seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/serial_display_scan.sv
// Captures ASCII hex characters into a NUM_DIGITS-deep shift buffer and
// time-multiplexes it onto a common-anode 7-segment array.
module serial_display_scan
    import serial_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LOWER_OK    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ascii_data,
    input  logic                  data_valid,
    output logic [7:0]            seven_segment_data,
    output logic [NUM_DIGITS-1:0] seven_segment_enable,
    output logic                  char_accepted,
    output logic                  char_error
);

    localparam int CNT_W = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
    localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  dv_q_r;
    logic                  capture_s;
    logic [4:0]            decode_s;
    logic                  char_valid_s;
    logic                  is_cr_s;
    digit_t                digit_buf_r [NUM_DIGITS];
    logic [CNT_W-1:0]      refresh_cnt_r;
    logic [IDX_W-1:0]      scan_idx_r;
    logic                  cnt_wrap_s;
    logic [4:0]            scan_digit_s;
    logic [7:0]            scan_seg_s;
    logic [NUM_DIGITS-1:0] enable_s;
    logic [7:0]            seg_data_r;
    logic [NUM_DIGITS-1:0] seg_enable_r;
    logic                  accepted_r;
    logic                  error_r;

    // Remember the previous data_valid level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q_r <= 1'b0;
        end else begin
            dv_q_r <= data_valid;
        end
    end

    // Classify the incoming character; only meaningful when capture_s is high.
    always_comb begin
        capture_s    = data_valid & ~dv_q_r;
        decode_s     = ascii_to_nibble(ascii_data, (LOWER_OK != 0));
        char_valid_s = decode_s[4];
        is_cr_s      = (ascii_data == ASCII_CR);
    end

    // Shift buffer: valid chars push in at entry 0, CR blanks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_buf_r[k] <= DIGIT_BLANK;
            end
        end else if (capture_s) begin
            if (char_valid_s) begin
                for (int k = NUM_DIGITS - 1; k > 0; k--) begin
                    digit_buf_r[k] <= digit_buf_r[k-1];
                end
                digit_buf_r[0] <= '{blank: 1'b0, nibble: decode_s[3:0]};
            end else if (is_cr_s) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    digit_buf_r[k] <= DIGIT_BLANK;
                end
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    digit_buf_r[k] <= digit_buf_r[k];
                end
            end
        end
    end

    // One-cycle status pulses; CR is neither accepted nor an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            accepted_r <= capture_s & char_valid_s;
            error_r    <= capture_s & ~char_valid_s & ~is_cr_s;
        end
    end

    // Wrap point of the dwell counter triggers the scan advance.
    always_comb begin
        cnt_wrap_s = (refresh_cnt_r == CNT_LAST);
    end

    // Dwell counter and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r    <= {IDX_W{1'b0}};
        end else if (cnt_wrap_s) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            if (scan_idx_r == IDX_LAST) begin
                scan_idx_r <= {IDX_W{1'b0}};
            end else begin
                scan_idx_r <= scan_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            refresh_cnt_r <= refresh_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Select the currently scanned entry and build the active-low digit strobe.
    always_comb begin
        scan_digit_s = digit_buf_r[scan_idx_r];
        enable_s     = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_r == IDX_W'(i)) begin
                enable_s[i] = 1'b0;
            end else begin
                enable_s[i] = 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .digit (scan_digit_s),
        .seg   (scan_seg_s)
    );

    // Data and strobe share one register stage so they switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_data_r   <= SEG_BLANK;
            seg_enable_r <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_data_r   <= {1'b1, scan_seg_s[6:0]};
            seg_enable_r <= enable_s;
        end
    end

    assign seven_segment_data   = seg_data_r;
    assign seven_segment_enable = seg_enable_r;
    assign char_accepted        = accepted_r;
    assign char_error           = error_r;

endmodule

// File: tb/tb_serial_display_scan.sv
// Scoreboard bench for serial_display_scan (4 digits, dwell of 4 cycles).
module tb_serial_display_scan;

    logic       clk;
    logic       rst_n;
    logic [7:0] ascii_data;
    logic       data_valid;
    logic [7:0] seven_segment_data;
    logic [3:0] seven_segment_enable;
    logic       char_accepted;
    logic       char_error;

    int errors = 0;
    int checks = 0;

    logic [4:0]  exp_buf [4];
    logic [11:0] scan_q [$];
    int          acc_q  [$];
    int          err_q  [$];
    logic [7:0]  seg_tab [16];

    serial_display_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .LOWER_OK    (1)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ascii_data           (ascii_data),
        .data_valid           (data_valid),
        .seven_segment_data   (seven_segment_data),
        .seven_segment_enable (seven_segment_enable),
        .char_accepted        (char_accepted),
        .char_error           (char_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Bench model of the character classes: returns {valid, nibble}.
    function automatic logic [4:0] model_decode(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b1, 4'(c - 8'h30)};
        if (c >= "A" && c <= "F") return {1'b1, 4'(c - 8'h37)};
        if (c >= "a" && c <= "f") return {1'b1, 4'(c - 8'h57)};
        return 5'b0_0000;
    endfunction

    function automatic logic [7:0] model_seg(input logic [4:0] e);
        if (e[4]) return 8'hFF;
        return seg_tab[e[3:0]];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) exp_buf[k] = 5'b1_0000;
    endtask

    // Drive one character with data_valid high for hold cycles, then count pulses.
    task automatic send_char(input logic [7:0] c, input int hold);
        logic [4:0] d;
        int a_cnt;
        int e_cnt;
        d = model_decode(c);
        if (d[4]) begin
            for (int k = 3; k > 0; k--) exp_buf[k] = exp_buf[k-1];
            exp_buf[0] = {1'b0, d[3:0]};
            acc_q.push_back(1);
            err_q.push_back(0);
        end else if (c == 8'h0D) begin
            model_clear();
            acc_q.push_back(0);
            err_q.push_back(0);
        end else begin
            acc_q.push_back(0);
            err_q.push_back(1);
        end
        a_cnt = 0;
        e_cnt = 0;
        ascii_data = c;
        data_valid = 1'b1;
        for (int i = 0; i < hold + 3; i++) begin
            @(negedge clk);
            if (char_accepted) a_cnt++;
            if (char_error) e_cnt++;
            if (i == hold - 1) data_valid = 1'b0;
        end
        check_value($sformatf("acc_%02h", c), a_cnt, acc_q.pop_front());
        check_value($sformatf("err_%02h", c), e_cnt, err_q.pop_front());
    endtask

    // Wait (bounded) for a given strobe pattern.
    task automatic wait_enable(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (seven_segment_enable == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Push the expected scan of all digits from the model, then compare one full sweep.
    task automatic scan_check(input string tag);
        bit ok;
        logic [11:0] e;
        for (int k = 0; k < 4; k++) begin
            scan_q.push_back({~(4'b0001 << k), model_seg(exp_buf[k])});
        end
        wait_enable(4'b1110, ok);
        check_value({tag, "_sync"}, ok, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e = scan_q.pop_front();
            check_value($sformatf("%s_en%0d", tag, k), seven_segment_enable, e[11:8]);
            check_value($sformatf("%s_seg%0d", tag, k), seven_segment_data, e[7:0]);
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int cnt;
        logic [3:0] prev;
        logic [3:0] nxt;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        model_clear();

        // Reset held with a pending valid character.
        rst_n      = 1'b0;
        ascii_data = "5";
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_seg", seven_segment_data, 8'hFF);
        check_value("rst_en", seven_segment_enable, 4'b1111);
        check_value("rst_acc", char_accepted, 1'b0);
        check_value("rst_err", char_error, 1'b0);
        data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        scan_check("blank");

        // Shift in four digits, then overflow.
        send_char("1", 1);
        send_char("2", 1);
        send_char("3", 1);
        send_char("4", 1);
        scan_check("shift");
        send_char("A", 1);
        scan_check("ovf");

        // Held data_valid captures once.
        send_char("F", 20);
        scan_check("held");

        // Invalid, lowercase and CR.
        send_char(8'h47, 1);
        scan_check("inval");
        send_char("b", 1);
        scan_check("lower");
        send_char(8'h0D, 1);
        scan_check("cr");

        // Dwell length and wrap of the strobe.
        prev = seven_segment_enable;
        cnt = 0;
        while (seven_segment_enable == prev && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        for (int j = 0; j < 5; j++) begin
            prev = seven_segment_enable;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (seven_segment_enable == prev && cnt < 10);
            nxt = (prev == 4'b0111) ? 4'b1110 : {prev[2:0], 1'b1};
            check_value($sformatf("dwell%0d", j), cnt, 4);
            check_value($sformatf("step%0d", j), seven_segment_enable, nxt);
        end

        // Asynchronous reset in the middle of a dwell with a capture pending.
        send_char("7", 1);
        wait_enable(4'b1110, ok);
        check_value("mid_sync", ok, 1'b1);
        check_value("mid_pre_seg", seven_segment_data, 8'hF8);
        ascii_data = "8";
        data_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_seg", seven_segment_data, 8'hFF);
        check_value("mid_rst_en", seven_segment_enable, 4'b1111);
        model_clear();
        repeat (2) @(negedge clk);
        check_value("mid_rst_acc", char_accepted, 1'b0);
        data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        scan_check("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
